// File: rtl/btn_debounce_bank_if.sv
// Button bank bus: raw inputs toward the conditioner, conditioned levels and pulses back.
interface btn_debounce_bank_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_i;
    logic [N_BTN-1:0] lvl_o;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic             any_press_o;

    modport master (output btn_i, input lvl_o, press_o, release_o, any_press_o);
    modport slave  (input btn_i, output lvl_o, press_o, release_o, any_press_o);
endinterface

// File: rtl/btn_debounce_bank.sv
// N-channel push-button conditioner: sync, stability debounce, level and press/release pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat press pulses.
module btn_debounce_ch #(
    parameter int STABLE_CYC = 1000000,
    parameter int ACT_LOW    = 0,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn,
    output logic lvl,
    output logic press,
    output logic rls,
    output logic press_nxt
);
    localparam int CW = $clog2(STABLE_CYC);

    if (STABLE_CYC < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
        $error("btn_debounce_ch: illegal timing parameters");
    end

    logic          b, s1, s2;
    logic [CW-1:0] cnt;
    logic          flip, rise_nxt, fall_nxt;

    assign b        = btn ^ 1'(ACT_LOW);
    assign flip     = (s2 != lvl) && (cnt == CW'(STABLE_CYC - 1));
    assign rise_nxt = flip & s2;
    assign fall_nxt = flip & ~s2;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rc;
    logic          rep_first;
    logic          rep_fire;

    // The release edge wins over a repeat landing on the same cycle.
    assign rep_fire  = lvl && !fall_nxt &&
                       (rc == (rep_first ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1)));
    assign press_nxt = rise_nxt | rep_fire;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rc        <= '0;
            rep_first <= 1'b1;
        end else if (!lvl) begin
            rc        <= '0;
            rep_first <= 1'b1;
        end else if (rep_fire) begin
            rc        <= '0;
            rep_first <= 1'b0;
        end else begin
            rc <= rc + RW'(1);
        end
    end
`else
    assign press_nxt = rise_nxt;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            s1    <= b;
            s2    <= s1;
            press <= press_nxt;
            rls   <= fall_nxt;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (flip) begin
                cnt <= '0;
                lvl <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module btn_debounce_bank #(
    parameter int N_BTN      = 2,
    parameter int STABLE_CYC = 1000000,
    parameter int ACT_LOW    = 0,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    btn_debounce_bank_if.slave bus
);
    logic [N_BTN-1:0] lvl, press, rls, press_nxt;
    logic             any_press;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CYC (STABLE_CYC),
            .ACT_LOW    (ACT_LOW),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .btn       (bus.btn_i[i]),
            .lvl       (lvl[i]),
            .press     (press[i]),
            .rls       (rls[i]),
            .press_nxt (press_nxt[i])
        );
    end

    // Reduced from the next-state pulses so it lines up with press_o.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) any_press <= 1'b0;
        else            any_press <= |press_nxt;
    end

    assign bus.lvl_o       = lvl;
    assign bus.press_o     = press;
    assign bus.release_o   = rls;
    assign bus.any_press_o = any_press;
endmodule
